regfile_write_ctrl: RTL and testbench

Write-side front end for the 8-entry x 16-bit register file. Accepts write-back requests from two producers, the ALU and the load unit, over independent valid/ready channels. Buffers each producer in its own FIFO and arbitrates round-robin. Drives the register file write port (wen/waddr/wdata) with at most one registered write per cycle. Exports a pending-write scoreboard so issue logic can stall on registers with queued writes.

---
 rtl/regfile_write_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_regfile_write_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_ctrl.sv
// Write-side front end for the register file: two per-producer FIFOs, round-robin
// arbitration into a single registered write port, plus a pending-write scoreboard.
module regfile_write_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned NREG  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_addr,
  input  logic [DW-1:0]            alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [AW-1:0]            mem_addr,
  input  logic [DW-1:0]            mem_data,
  output logic                     wen,
  output logic [AW-1:0]            waddr,
  output logic [DW-1:0]            wdata,
  output logic [NREG-1:0]          pending,
  output logic [$clog2(DEPTH):0]   alu_count,
  output logic [$clog2(DEPTH):0]   mem_count,
  output logic                     err_drop
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [AW:0] NREG_LIM = (AW+1)'(NREG);

  // Source index 0 is the ALU, 1 is the load unit.
  logic [AW-1:0] addr_q [2][DEPTH];
  logic [AW-1:0] addr_d [2][DEPTH];
  logic [DW-1:0] data_q [2][DEPTH];
  logic [DW-1:0] data_d [2][DEPTH];
  logic [PW-1:0] rd_q [2];
  logic [PW-1:0] rd_d [2];
  logic [PW-1:0] wr_q [2];
  logic [PW-1:0] wr_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  logic          rr_q, rr_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_drop_q, err_drop_d;

  logic [1:0]    in_valid, ready, ne, push, pop;
  logic [AW-1:0] in_addr [2];
  logic [DW-1:0] in_data [2];
  logic          sel;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          in_range;
  logic [PW-1:0] off;

  assign in_valid   = {mem_valid, alu_valid};
  assign in_addr[0] = alu_addr;
  assign in_addr[1] = mem_addr;
  assign in_data[0] = alu_data;
  assign in_data[1] = mem_data;

  // Ready depends on occupancy only, so a full FIFO refuses even on a pop edge.
  assign ready[0] = cnt_q[0] < CW'(DEPTH);
  assign ready[1] = cnt_q[1] < CW'(DEPTH);
  assign ne[0]    = cnt_q[0] != '0;
  assign ne[1]    = cnt_q[1] != '0;
  assign push     = in_valid & ready;

  // rr_q = 0 favours the ALU when both sources have entries.
  assign pop[0]    = ne[0] & (~ne[1] | ~rr_q);
  assign pop[1]    = ne[1] & (~ne[0] | rr_q);
  assign sel       = pop[1];
  assign head_addr = addr_q[sel][rd_q[sel]];
  assign head_data = data_q[sel][rd_q[sel]];
  assign in_range  = {1'b0, head_addr} < NREG_LIM;

  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_drop_d = err_drop_q;

    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        addr_d[s][wr_q[s]] = in_addr[s];
        data_d[s][wr_q[s]] = in_data[s];
        wr_d[s]            = wr_q[s] + PW'(1);
      end
      if (pop[s]) begin
        rd_d[s] = rd_q[s] + PW'(1);
      end
      cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
    end

    if (&ne) begin
      rr_d = ~rr_q;
    end

    // Out-of-range entries still use the slot but never reach the write port.
    if (|pop) begin
      if (in_range) begin
        wen_d   = 1'b1;
        waddr_d = head_addr;
        wdata_d = head_data;
      end else begin
        err_drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < int'(DEPTH); k++) begin
          addr_q[s][k] <= '0;
          data_q[s][k] <= '0;
        end
        rd_q[s]  <= '0;
        wr_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
      rr_q       <= 1'b0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_drop_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_drop_q <= err_drop_d;
    end
  end

  // Scoreboard: a slot is live when its distance from the read pointer is below the count.
  always_comb begin
    pending = '0;
    off     = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        off = PW'(k) - rd_q[s];
        if (CW'(off) < cnt_q[s]) begin
          for (int i = 0; i < int'(NREG); i++) begin
            if (addr_q[s][k] == AW'(i)) pending[i] = 1'b1;
          end
        end
      end
    end
    if (wen_q) begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (waddr_q == AW'(i)) pending[i] = 1'b1;
      end
    end
  end

  assign alu_ready = ready[0];
  assign mem_ready = ready[1];
  assign alu_count = cnt_q[0];
  assign mem_count = cnt_q[1];
  assign wen       = wen_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: latency, arbitration order, backpressure,
// out-of-range drop, mid-stream reset and pointer wrap.
module tb_regfile_write_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned NREG  = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk, rst;
  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [AW-1:0] alu_addr, mem_addr, waddr;
  logic [DW-1:0] alu_data, mem_data, wdata;
  logic          wen, err_drop;
  logic [NREG-1:0] pending;
  logic [CW-1:0] alu_count, mem_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [DW-1:0] wd_q [$];
  logic [AW-1:0] wa_q [$];
  int            wc_q [$];

  regfile_write_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wen(wen), .waddr(waddr), .wdata(wdata), .pending(pending),
    .alu_count(alu_count), .mem_count(mem_count), .err_drop(err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then log any register-file write seen in the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (wen) begin
      wd_q.push_back(wdata);
      wa_q.push_back(waddr);
      wc_q.push_back(cyc);
    end
  endtask

  task automatic clear_log();
    wd_q.delete();
    wa_q.delete();
    wc_q.delete();
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp2 [6];
    int na, nm;

    rst = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_wen", 32'(wen), 32'd0);
    check_eq("rst_waddr", 32'(waddr), 32'd0);
    check_eq("rst_wdata", 32'(wdata), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_alu_count", 32'(alu_count), 32'd0);
    check_eq("rst_mem_count", 32'(mem_count), 32'd0);
    check_eq("rst_err", 32'(err_drop), 32'd0);
    check_eq("rst_ready", 32'({alu_ready, mem_ready}), 32'd3);
    rst = 1'b0;

    // Single ALU write: two-edge latency, one-cycle wen, pending tracking
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'hBEEF;
    step();
    alu_valid = 1'b0;
    check_eq("t1_count", 32'(alu_count), 32'd1);
    check_eq("t1_wen_early", 32'(wen), 32'd0);
    check_eq("t1_pend_q", 32'(pending), 32'h08);
    step();
    check_eq("t1_wen", 32'(wen), 32'd1);
    check_eq("t1_waddr", 32'(waddr), 32'd3);
    check_eq("t1_wdata", 32'(wdata), 32'hBEEF);
    check_eq("t1_pend_w", 32'(pending), 32'h08);
    step();
    check_eq("t1_wen_off", 32'(wen), 32'd0);
    check_eq("t1_pend_off", 32'(pending), 32'd0);

    // Both sources every cycle: strict alternation, ALU first, no gaps
    clear_log();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_addr = 4'd1; alu_data = DW'(i + 1);
      mem_valid = 1'b1; mem_addr = 4'd2; mem_data = DW'(16'hA + i);
      step();
    end
    idle();
    repeat (6) step();
    exp2 = '{16'h1, 16'hA, 16'h2, 16'hB, 16'h3, 16'hC};
    check_eq("t2_nwrites", 32'(wd_q.size()), 32'd6);
    if (wd_q.size() == 6) begin
      for (int i = 0; i < 6; i++) check_eq($sformatf("t2_data%0d", i), 32'(wd_q[i]), 32'(exp2[i]));
      check_eq("t2_span", 32'(wc_q[5] - wc_q[0]), 32'd5);
    end

    // Out-of-range load write is dropped and flagged; next write proceeds
    mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 16'h1234;
    step();
    mem_valid = 1'b0;
    check_eq("t4_count", 32'(mem_count), 32'd1);
    check_eq("t4_pend", 32'(pending), 32'd0);
    step();
    check_eq("t4_wen", 32'(wen), 32'd0);
    check_eq("t4_waddr", 32'(waddr), 32'd2);
    check_eq("t4_wdata", 32'(wdata), 32'hC);
    check_eq("t4_err", 32'(err_drop), 32'd1);
    check_eq("t4_count0", 32'(mem_count), 32'd0);
    repeat (2) step();
    check_eq("t4_err_held", 32'(err_drop), 32'd1);
    mem_valid = 1'b1; mem_addr = 4'd4; mem_data = 16'h5555;
    step();
    mem_valid = 1'b0;
    step();
    check_eq("t4_next_wen", 32'(wen), 32'd1);
    check_eq("t4_next_waddr", 32'(waddr), 32'd4);
    check_eq("t4_next_wdata", 32'(wdata), 32'h5555);
    step();

    // Backpressure: pointer now favours the load unit, so the ALU FIFO fills first
    clear_log();
    for (int e = 0; e < 7; e++) begin
      alu_valid = 1'b1; alu_addr = 4'd5; alu_data = DW'(16'h30 + e);
      mem_valid = 1'b1; mem_addr = 4'd6; mem_data = DW'(16'h40 + e);
      step();
      if (e == 5) begin
        check_eq("t3_full_count", 32'(alu_count), 32'(DEPTH));
        check_eq("t3_full_ready", 32'(alu_ready), 32'd0);
        check_eq("t3_mem_count", 32'(mem_count), 32'd3);
      end
    end
    idle();
    check_eq("t3_popedge_count", 32'(alu_count), 32'd3);
    check_eq("t3_mem_full", 32'(mem_count), 32'(DEPTH));
    check_eq("t3_mem_ready", 32'(mem_ready), 32'd0);
    repeat (8) step();
    na = 0; nm = 0;
    for (int i = 0; i < wd_q.size(); i++) begin
      if (wa_q[i] == 4'd5) begin
        check_eq($sformatf("t3_alu%0d", na), 32'(wd_q[i]), 32'h30 + 32'(na));
        na++;
      end else begin
        check_eq($sformatf("t3_mem%0d", nm), 32'(wd_q[i]), 32'h40 + 32'(nm));
        nm++;
      end
    end
    check_eq("t3_alu_n", 32'(na), 32'd6);
    check_eq("t3_mem_n", 32'(nm), 32'd7);

    // Mid-stream reset discards queued entries and the in-flight write
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_addr = 4'(1 + i); alu_data = DW'(16'h70 + i);
      mem_valid = 1'b1; mem_addr = 4'(4 + i); mem_data = DW'(16'h80 + i);
      step();
    end
    idle();
    check_eq("t5_pre_counts", 32'({alu_count, mem_count}), 32'({3'd2, 3'd2}));
    check_eq("t5_pre_wen", 32'({wen, waddr}), 32'h11);
    check_eq("t5_pre_pend", 32'(pending), 32'h6E);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_wen", 32'(wen), 32'd0);
    check_eq("t5_counts", 32'({alu_count, mem_count}), 32'd0);
    check_eq("t5_pend", 32'(pending), 32'd0);
    check_eq("t5_err", 32'(err_drop), 32'd0);
    check_eq("t5_wdata", 32'(wdata), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    repeat (5) step();
    check_eq("t5_no_stale", 32'(wd_q.size()), 32'd0);

    // Pointer wrap with random idle gaps on one source
    clear_log();
    for (int k = 0; k < 3 * int'(DEPTH); k++) begin
      repeat ($urandom_range(0, 2)) step();
      alu_valid = 1'b1; alu_addr = 4'd7; alu_data = DW'(16'h600 + k);
      check_eq($sformatf("t6_ready%0d", k), 32'(alu_ready), 32'd1);
      step();
      alu_valid = 1'b0;
    end
    repeat (4) step();
    check_eq("t6_n", 32'(wd_q.size()), 32'(3 * DEPTH));
    for (int k = 0; k < wd_q.size(); k++) begin
      check_eq($sformatf("t6_data%0d", k), 32'(wd_q[k]), 32'h600 + 32'(k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
